// File: rtl/calc_arbiter.sv
// Purpose  : two-requester round-robin arbiter sharing one calc accumulator; bursts lock the owner.
// Latency  : 4 cycles per op minimum (grant, strobe, capture, response); IDLE adds a bubble after a last beat.
// Backpress: req_ready is offered to one requester at a time; the response is held until rsp_ready[owner].
//
// Ports
//   clk, btnac_n                 clock and synchronous active-low reset (also clears the calc)
//   req_valid/ready/op/data/     per-requester request channel, bit/field 0 = A, 1 = B;
//   req_clr/req_last             clr requests an accumulator clear, last=0 keeps the lock
//   rsp_valid/ready, rsp_data    per-requester response channel carrying the post-op accumulator
//   calc_btnc/btnac/btnl/r/d/sw  drive side of the calc datapath; calc_led is its accumulator
//   owner, busy, timeout_err     last granted requester, FSM not idle, forced lock release pulse
module calc_arbiter #(
    parameter int DATA_W       = 16,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  btnac_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [5:0]            req_op,
    input  logic [2*DATA_W-1:0]   req_data,
    input  logic [1:0]            req_clr,
    input  logic [1:0]            req_last,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  calc_btnc,
    output logic                  calc_btnac,
    output logic                  calc_btnl,
    output logic                  calc_btnr,
    output logic                  calc_btnd,
    output logic [DATA_W-1:0]     calc_sw,
    input  logic [DATA_W-1:0]     calc_led,
    output logic                  owner,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    // Timer wide enough to reach LOCK_TIMEOUT-1; a zero timeout never compares.
    localparam int             TW   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMAX = TW'(LOCK_TIMEOUT - 1);

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] data;
        logic              clr;
        logic              last;
    } req_t;

    logic [2:0]    state;
    req_t          lat_q;      // request currently driving the calc
    req_t          sel_req;    // request of the requester being granted this cycle
    logic          grant_vld;
    logic          grant_sel;
    logic          pref;       // requester that wins when both are valid in IDLE
    logic [TW-1:0] hold_tmr;
    logic          hold_expire;

    // Grant selection. In IDLE a lone requester wins; a tie goes to pref,
    // which always points away from the last winner (A out of reset).
    // In HOLD only the lock owner may be accepted.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        req_ready = 2'b00;
        if (btnac_n) begin
            case (state)
                S_IDLE: begin
                    if (req_valid == 2'b11) begin
                        grant_vld = 1'b1;
                        grant_sel = pref;
                    end else if (req_valid[0]) begin
                        grant_vld = 1'b1;
                        grant_sel = 1'b0;
                    end else if (req_valid[1]) begin
                        grant_vld = 1'b1;
                        grant_sel = 1'b1;
                    end
                    if (grant_vld) begin
                        req_ready[grant_sel] = 1'b1;
                    end
                end
                S_HOLD: begin
                    req_ready[owner] = 1'b1;
                    grant_vld        = req_valid[owner];
                    grant_sel        = owner;
                end
                default: begin
                    grant_vld = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        if (grant_sel) begin
            sel_req.op   = req_op[5:3];
            sel_req.data = req_data[2*DATA_W-1:DATA_W];
            sel_req.clr  = req_clr[1];
            sel_req.last = req_last[1];
        end else begin
            sel_req.op   = req_op[2:0];
            sel_req.data = req_data[DATA_W-1:0];
            sel_req.clr  = req_clr[0];
            sel_req.last = req_last[0];
        end
    end

    assign hold_expire = (LOCK_TIMEOUT != 0) && (hold_tmr == TMAX);

    always_ff @(posedge clk) begin
        if (!btnac_n) begin
            state       <= S_IDLE;
            lat_q       <= '0;
            owner       <= 1'b0;
            pref        <= 1'b0;
            rsp_data    <= '0;
            hold_tmr    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        lat_q <= sel_req;
                        owner <= grant_sel;
                        pref  <= ~grant_sel;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    // calc_led reflects the strobe issued one cycle earlier.
                    rsp_data <= calc_led;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        hold_tmr <= '0;
                        state    <= lat_q.last ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    // A beat arriving on the expiry cycle still continues the burst.
                    if (grant_vld) begin
                        lat_q <= sel_req;
                        state <= S_ISSUE;
                    end else if (hold_expire) begin
                        timeout_err <= 1'b1;
                        pref        <= ~owner;
                        state       <= S_IDLE;
                    end else begin
                        hold_tmr <= hold_tmr + TW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state == S_RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    assign calc_btnc  = btnac_n && (state == S_ISSUE) && !lat_q.clr;
    assign calc_btnac = !btnac_n || ((state == S_ISSUE) && lat_q.clr);
    assign calc_btnl  = lat_q.op[2];
    assign calc_btnr  = lat_q.op[1];
    assign calc_btnd  = lat_q.op[0];
    assign calc_sw    = lat_q.data;
    assign busy       = (state != S_IDLE);

endmodule
